// File: rtl/framebuffer_packer_if.sv
// -----------------------------------------------------------------------------
// framebuffer_packer_if
// Word bus from the frame-buffer packer toward the DRAM write path.
//   word_valid : FIFO head valid (packer -> DRAM)
//   word_ready : DRAM side accepts the head (DRAM -> packer)
//   word_data  : 8 RGB565 lanes, lane n in bits [16n+15:16n]
//   word_addr  : word index = v_count*160 + h_count[10:3]
//   word_strb  : byte enables, 2 bits per lane
//   word_last  : word holds the frame's final pixel
// -----------------------------------------------------------------------------
interface framebuffer_packer_if;
    logic         word_valid;
    logic         word_ready;
    logic [127:0] word_data;
    logic [16:0]  word_addr;
    logic [15:0]  word_strb;
    logic         word_last;

    modport master (
        output word_valid,
        output word_data,
        output word_addr,
        output word_strb,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  word_addr,
        input  word_strb,
        input  word_last,
        output word_ready
    );
endinterface

// File: rtl/framebuffer_packer.sv
// -----------------------------------------------------------------------------
// framebuffer_packer
// Packs a non-stallable RGB565 pixel stream into 128-bit, 8-pixel words with
// byte strobes and queues them in a small FIFO toward DRAM (valid/ready).
// Losses (out-of-range pixels, pushes into a full FIFO) are counted, not
// back-pressured.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_h_count       : pixel column (11 bits)
//   i_v_count       : pixel row (10 bits)
//   i_pixel_valid   : pixel qualifier, at most one every 2 cycles
//   i_pixel_last    : final pixel of frame (qualified by i_pixel_valid)
//   i_pixel_data    : RGB565 pixel
//   word_if         : word bus (master side), see framebuffer_packer_if
//   o_frame_done    : 1-cycle pulse after a word_last transfer
//   o_overflow      : sticky loss flag (full-FIFO push)
//   o_drop_count    : saturating count of dropped pixels and words
// -----------------------------------------------------------------------------
module framebuffer_packer #(
    parameter int PIXELS_PER_WORD = 8,
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [10:0]                 i_h_count,
    input  logic [9:0]                  i_v_count,
    input  logic                        i_pixel_valid,
    input  logic                        i_pixel_last,
    input  logic [15:0]                 i_pixel_data,
    framebuffer_packer_if.master        word_if,
    output logic                        o_frame_done,
    output logic                        o_overflow,
    output logic [15:0]                 o_drop_count
);
    localparam int DATA_W = 16 * PIXELS_PER_WORD;
    localparam int STRB_W = 2 * PIXELS_PER_WORD;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Accumulator: empty whenever r_acc_strb is zero; data is kept zero when empty
    logic [DATA_W-1:0] r_acc_data;
    logic [STRB_W-1:0] r_acc_strb;
    logic [16:0]       r_acc_addr;

    // Pending slot for a completed word that lost push arbitration to a flush
    logic              r_pend_valid;
    logic [DATA_W-1:0] r_pend_data;
    logic [STRB_W-1:0] r_pend_strb;
    logic [16:0]       r_pend_addr;
    logic              r_pend_last;

    // Output FIFO
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [STRB_W-1:0] r_mem_strb [FIFO_DEPTH];
    logic [16:0]       r_mem_addr [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_frame_done;
    logic              r_overflow;
    logic [15:0]       r_drop_count;

    logic              w_in_range;
    logic [16:0]       w_v_ext;
    logic [16:0]       w_idx;
    logic [2:0]        w_lane;
    logic              w_acc_busy;
    logic              w_take;
    logic              w_pix_drop;
    logic              w_mismatch;
    logic              w_oor_flush;
    logic [DATA_W-1:0] w_new_data;
    logic [STRB_W-1:0] w_new_strb;
    logic              w_complete;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic [STRB_W-1:0] w_push_strb;
    logic [16:0]       w_push_addr;
    logic              w_push_last;
    logic              w_pend_load;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_push_drop;
    logic [1:0]        w_drop_inc;
    logic [16:0]       w_drop_sum;

    // Pixel decode, accumulator merge and push arbitration
    always_comb begin
        w_in_range  = (i_h_count < 11'(H_ACTIVE)) && (i_v_count < 10'(V_ACTIVE));
        w_v_ext     = {7'd0, i_v_count};
        // v*160 = v*128 + v*32
        w_idx       = (w_v_ext << 3'd7) + (w_v_ext << 3'd5) + {9'd0, i_h_count[10:3]};
        w_lane      = i_h_count[2:0];
        w_acc_busy  = (r_acc_strb != {STRB_W{1'b0}});
        w_take      = i_pixel_valid && w_in_range;
        w_pix_drop  = i_pixel_valid && !w_in_range;
        w_mismatch  = w_take && w_acc_busy && (w_idx != r_acc_addr);
        // A dropped last pixel still closes out the frame's partial word
        w_oor_flush = w_pix_drop && i_pixel_last && w_acc_busy;

        // On an index change the new pixel starts from a clean word
        w_new_data  = w_mismatch ? {DATA_W{1'b0}} : r_acc_data;
        w_new_strb  = w_mismatch ? {STRB_W{1'b0}} : r_acc_strb;
        w_new_data[{w_lane, 4'b0000} +: 16] = i_pixel_data;
        w_new_strb  = w_new_strb | (STRB_W'(2'b11) << {w_lane, 1'b0});
        w_complete  = w_take && ((&w_new_strb) || i_pixel_last);

        w_push      = 1'b0;
        w_push_data = r_acc_data;
        w_push_strb = r_acc_strb;
        w_push_addr = r_acc_addr;
        w_push_last = 1'b0;
        w_pend_load = 1'b0;
        if (r_pend_valid) begin
            w_push      = 1'b1;
            w_push_data = r_pend_data;
            w_push_strb = r_pend_strb;
            w_push_addr = r_pend_addr;
            w_push_last = r_pend_last;
        end else if (w_mismatch || w_oor_flush) begin
            // Old word goes now; a same-cycle completion waits one cycle
            w_push      = 1'b1;
            w_push_last = w_oor_flush;
            w_pend_load = w_complete;
        end else if (w_complete) begin
            w_push      = 1'b1;
            w_push_data = w_new_data;
            w_push_strb = w_new_strb;
            w_push_addr = w_idx;
            w_push_last = i_pixel_last;
        end else begin
            w_push      = 1'b0;
        end

        w_pop       = (r_count != {CNT_W{1'b0}}) && word_if.word_ready;
        w_full      = (r_count == FULL_CNT);
        // A same-cycle pop frees the slot for a push into a full FIFO
        w_push_ok   = w_push && (!w_full || w_pop);
        w_push_drop = w_push && w_full && !w_pop;
        w_drop_inc  = {1'b0, w_pix_drop} + {1'b0, w_push_drop};
        w_drop_sum  = {1'b0, r_drop_count} + {15'd0, w_drop_inc};
    end

    // Accumulator and pending register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data   <= {DATA_W{1'b0}};
            r_acc_strb   <= {STRB_W{1'b0}};
            r_acc_addr   <= 17'd0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= {DATA_W{1'b0}};
            r_pend_strb  <= {STRB_W{1'b0}};
            r_pend_addr  <= 17'd0;
            r_pend_last  <= 1'b0;
        end else begin
            if (w_oor_flush || w_complete) begin
                r_acc_data <= {DATA_W{1'b0}};
                r_acc_strb <= {STRB_W{1'b0}};
            end else if (w_take) begin
                r_acc_data <= w_new_data;
                r_acc_strb <= w_new_strb;
                r_acc_addr <= w_idx;
            end else begin
                r_acc_data <= r_acc_data;
            end
            r_pend_valid <= w_pend_load;
            if (w_pend_load) begin
                r_pend_data <= w_new_data;
                r_pend_strb <= w_new_strb;
                r_pend_addr <= w_idx;
                r_pend_last <= i_pixel_last;
            end else begin
                r_pend_data <= r_pend_data;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= {DATA_W{1'b0}};
                r_mem_strb[i] <= {STRB_W{1'b0}};
                r_mem_addr[i] <= 17'd0;
                r_mem_last[i] <= 1'b0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_strb[r_wr_ptr] <= w_push_strb;
                r_mem_addr[r_wr_ptr] <= w_push_addr;
                r_mem_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status: frame-done pulse, sticky overflow, saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_frame_done <= w_pop && r_mem_last[r_rd_ptr];
            r_overflow   <= r_overflow || w_push_drop;
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign word_if.word_valid = (r_count != {CNT_W{1'b0}});
    assign word_if.word_data  = r_mem_data[r_rd_ptr];
    assign word_if.word_addr  = r_mem_addr[r_rd_ptr];
    assign word_if.word_strb  = r_mem_strb[r_rd_ptr];
    assign word_if.word_last  = r_mem_last[r_rd_ptr];
    assign o_frame_done       = r_frame_done;
    assign o_overflow         = r_overflow;
    assign o_drop_count       = r_drop_count;
endmodule
